// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID-stage, memory-wait and control signal bundle of the hazard controller
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic             id_rs1_used;
    logic [REG_W-1:0] id_rs2;
    logic             id_rs2_used;
    logic [REG_W-1:0] id_rd;
    logic             id_rfwr;
    logic             id_is_load;
    logic             branch;
    logic             mem_busy;

    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             freeze;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: supplies ID contents and events, consumes control
    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
        output id_rd, id_rfwr, id_is_load, branch, mem_busy,
        input  pc_stall, ifid_stall, ifid_flush, idex_bubble, freeze,
        input  fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    // Controller side
    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
        input  id_rd, id_rfwr, id_is_load, branch, mem_busy,
        output pc_stall, ifid_stall, ifid_flush, idex_bubble, freeze,
        output fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard, flush, freeze and forwarding controller
module pipe_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);

    // EX shadow entry (also carries the operand indices for forwarding)
    logic             ex_v_q,        ex_v_d;
    logic [REG_W-1:0] ex_rd_q,       ex_rd_d;
    logic             ex_rfwr_q,     ex_rfwr_d;
    logic             ex_ld_q,       ex_ld_d;
    logic [REG_W-1:0] ex_rs1_q,      ex_rs1_d;
    logic             ex_rs1_used_q, ex_rs1_used_d;
    logic [REG_W-1:0] ex_rs2_q,      ex_rs2_d;
    logic             ex_rs2_used_q, ex_rs2_used_d;

    // MEM shadow entry
    logic             mem_v_q,    mem_v_d;
    logic [REG_W-1:0] mem_rd_q,   mem_rd_d;
    logic             mem_rfwr_q, mem_rfwr_d;
    logic             mem_ld_q,   mem_ld_d;

    // WB shadow entry; its load flag has no consumer so it is not kept
    logic             wb_v_q,    wb_v_d;
    logic [REG_W-1:0] wb_rd_q,   wb_rd_d;
    logic             wb_rfwr_q, wb_rfwr_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu;
    logic freeze_c;
    logic flush_c;
    logic stall_c;
    logic bubble_c;
    logic [1:0] fwd_a_c;
    logic [1:0] fwd_b_c;

    // An entry produces r only when live, writing, and r is not x0
    function automatic logic writes_reg(
        input logic             v,
        input logic             rfwr,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] r
    );
        return v && rfwr && (rd == r) && (r != '0);
    endfunction

    // MEM is the youngest producer; a MEM load cannot supply its data yet
    function automatic logic [1:0] fwd_sel(
        input logic             ex_v,
        input logic             used,
        input logic [REG_W-1:0] rs,
        input logic             m_v,
        input logic             m_rfwr,
        input logic [REG_W-1:0] m_rd,
        input logic             m_ld,
        input logic             w_v,
        input logic             w_rfwr,
        input logic [REG_W-1:0] w_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_v && used) begin
            if (writes_reg(m_v, m_rfwr, m_rd, rs)) begin
                sel = m_ld ? 2'b00 : 2'b01;
            end else if (writes_reg(w_v, w_rfwr, w_rd, rs)) begin
                sel = 2'b10;
            end
        end
        return sel;
    endfunction

    // Hazard detection and prioritised control: freeze > flush > stall
    always_comb begin
        lu = bus.id_valid && ex_ld_q &&
             ((bus.id_rs1_used && writes_reg(ex_v_q, ex_rfwr_q, ex_rd_q, bus.id_rs1)) ||
              (bus.id_rs2_used && writes_reg(ex_v_q, ex_rfwr_q, ex_rd_q, bus.id_rs2)));
        freeze_c = 1'b0;
        flush_c  = 1'b0;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        // Gating by rst keeps all controls low while reset is held
        if (rst) begin
            if (bus.mem_busy) begin
                freeze_c = 1'b1;
            end else if (bus.branch) begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
            end else if (lu) begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
            end
        end
    end

    // Forwarding selects depend only on registered shadow state
    always_comb begin
        fwd_a_c = fwd_sel(ex_v_q, ex_rs1_used_q, ex_rs1_q,
                          mem_v_q, mem_rfwr_q, mem_rd_q, mem_ld_q,
                          wb_v_q, wb_rfwr_q, wb_rd_q);
        fwd_b_c = fwd_sel(ex_v_q, ex_rs2_used_q, ex_rs2_q,
                          mem_v_q, mem_rfwr_q, mem_rd_q, mem_ld_q,
                          wb_v_q, wb_rfwr_q, wb_rd_q);
    end

    // Next shadow state and counters: everything holds while frozen
    always_comb begin
        ex_v_d        = ex_v_q;
        ex_rd_d       = ex_rd_q;
        ex_rfwr_d     = ex_rfwr_q;
        ex_ld_d       = ex_ld_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs1_used_d = ex_rs1_used_q;
        ex_rs2_d      = ex_rs2_q;
        ex_rs2_used_d = ex_rs2_used_q;
        mem_v_d       = mem_v_q;
        mem_rd_d      = mem_rd_q;
        mem_rfwr_d    = mem_rfwr_q;
        mem_ld_d      = mem_ld_q;
        wb_v_d        = wb_v_q;
        wb_rd_d       = wb_rd_q;
        wb_rfwr_d     = wb_rfwr_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        if (!freeze_c) begin
            wb_v_d        = mem_v_q;
            wb_rd_d       = mem_rd_q;
            wb_rfwr_d     = mem_rfwr_q;
            mem_v_d       = ex_v_q;
            mem_rd_d      = ex_rd_q;
            mem_rfwr_d    = ex_rfwr_q;
            mem_ld_d      = ex_ld_q;
            // A bubble only kills the valid bit; the other fields are don't-care
            ex_v_d        = bus.id_valid && !bubble_c;
            ex_rd_d       = bus.id_rd;
            ex_rfwr_d     = bus.id_rfwr;
            ex_ld_d       = bus.id_is_load;
            ex_rs1_d      = bus.id_rs1;
            ex_rs1_used_d = bus.id_rs1_used;
            ex_rs2_d      = bus.id_rs2;
            ex_rs2_used_d = bus.id_rs2_used;
            if (flush_c && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
            if (stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Shadow scoreboard and counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_v_q        <= 1'b0;
            ex_rd_q       <= '0;
            ex_rfwr_q     <= 1'b0;
            ex_ld_q       <= 1'b0;
            ex_rs1_q      <= '0;
            ex_rs1_used_q <= 1'b0;
            ex_rs2_q      <= '0;
            ex_rs2_used_q <= 1'b0;
            mem_v_q       <= 1'b0;
            mem_rd_q      <= '0;
            mem_rfwr_q    <= 1'b0;
            mem_ld_q      <= 1'b0;
            wb_v_q        <= 1'b0;
            wb_rd_q       <= '0;
            wb_rfwr_q     <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            ex_v_q        <= ex_v_d;
            ex_rd_q       <= ex_rd_d;
            ex_rfwr_q     <= ex_rfwr_d;
            ex_ld_q       <= ex_ld_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs1_used_q <= ex_rs1_used_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_rs2_used_q <= ex_rs2_used_d;
            mem_v_q       <= mem_v_d;
            mem_rd_q      <= mem_rd_d;
            mem_rfwr_q    <= mem_rfwr_d;
            mem_ld_q      <= mem_ld_d;
            wb_v_q        <= wb_v_d;
            wb_rd_q       <= wb_rd_d;
            wb_rfwr_q     <= wb_rfwr_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign bus.freeze      = freeze_c;
    assign bus.pc_stall    = stall_c;
    assign bus.ifid_stall  = stall_c;
    assign bus.ifid_flush  = flush_c;
    assign bus.idex_bubble = bubble_c;
    assign bus.fwd_a       = fwd_a_c;
    assign bus.fwd_b       = fwd_b_c;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Keeps a shadow scoreboard of the in-flight destination registers in EX, MEM and WB.
- From it, drives stall, bubble and flush of the IF/ID and ID/EX pipeline registers, global freeze on data-memory wait, and EX-stage operand forwarding selects.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- REG_W, 5, register index width
- CNT_W, 16, width of stall_cnt and flush_cnt

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a live instruction (IF/ID running)
- id_rs1  in  REG_W  ID source 1 index
- id_rs1_used  in  1  source 1 read (0 when ASel selects non-register operand)
- id_rs2  in  REG_W  ID source 2 index
- id_rs2_used  in  1  source 2 read (0 when BSel selects immediate)
- id_rd  in  REG_W  ID destination index
- id_rfwr  in  1  ID instruction writes register file
- id_is_load  in  1  ID instruction is a load (WDSel = memory)
- branch  in  1  taken branch/jump resolved in EX this cycle
- mem_busy  in  1  data memory not ready; whole pipeline must hold
- pc_stall  out  1  PC holds
- ifid_stall  out  1  IF/ID holds
- ifid_flush  out  1  IF/ID cleared
- idex_bubble  out  1  ID/EX loads bubble (running=0)
- freeze  out  1  all pipeline registers hold
- fwd_a  out  2  EX operand A: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- fwd_b  out  2  EX operand B, same encoding
- stall_cnt  out  CNT_W  load-use stall cycles, saturating
- flush_cnt  out  CNT_W  branch flush events, saturating

Behaviour:
- Shadow state, one entry each for EX, MEM and WB: v, rd, rfwr, ld. The EX entry additionally holds rs1/rs2 indices and their used flags.
- Reset (rst=0, asynchronous): all v=0, all fields 0, both counters 0.
  - Consequence: combinational outputs are all 0 while in reset.
- An entry "writes r" when v & rfwr & rd==r & r!=0. Register x0 never matches.
- Load-use hazard, lu: id_valid & EX entry is a load that writes id_rs1 (with id_rs1_used) or id_rs2 (with id_rs2_used).
- Control outputs are combinational, same cycle, with priority freeze > flush > stall:
  - freeze = mem_busy. When freeze=1, all other control outputs are 0, the shadow state holds, and the counters hold.
  - Else if branch: ifid_flush=1 and idex_bubble=1, stalls 0; flush_cnt increments. An lu in the same cycle is ignored and does not count.
  - Else if lu: pc_stall=1, ifid_stall=1, idex_bubble=1; stall_cnt increments.
  - Else all control outputs are 0.
- Shadow advance on each non-frozen clock edge: WB<=MEM and MEM<=EX.
  - EX<=ID fields with v=id_valid when no bubble; otherwise EX.v<=0.
- branch is sampled only when mem_busy=0. The source holds branch high through freeze.
- Forwarding selects are combinational from registered state only. For A, using EX rs1 and EX rs1_used:
  - 01 if the MEM entry writes rs1 and MEM.ld=0;
  - else 10 if the WB entry writes rs1;
  - else 00.
  - The MEM match takes priority as the youngest producer.
  - fwd_b is the same using rs2.
  - Both selects are 00 when EX.v=0 or the corresponding used flag is 0.
- A MEM-stage load matching an EX source cannot occur, because lu has already inserted a bubble. If it is reached anyway (for example, the sequence is broken by reset), select 00.
- Counters saturate at all-ones; they do not wrap.
- Reset asserted mid-stall or mid-freeze: state clears immediately and outputs go 0 without waiting for a clock edge.

Test Plan:
- Back-to-back ALU dependency: add x5 then sub x6,x5,x7, no busy → EX cycle of sub shows fwd_a=01, no stall, stall_cnt=0.
- Load-use: lw x5 then add x6,x5,x1 → one cycle with pc_stall=ifid_stall=idex_bubble=1 and stall_cnt=1; next cycle fwd_a=10.
- x0 destination: lw x0 then add x6,x0,x1 → no stall, fwd_a=00.
- Branch with simultaneous lu → ifid_flush=idex_bubble=1, pc_stall=0, flush_cnt=1, stall_cnt unchanged, EX shadow v=0 next cycle.
- mem_busy held 3 cycles during a pending lu → freeze=1 and other outputs 0 for 3 cycles, shadow and counters unchanged; the stall is then issued.
- Saturation and async reset: preload stall_cnt to 0xFFFF via repeated lu → stays 0xFFFF; drop rst mid-cycle → all outputs 0 before the next clk edge.
